apb_fll_if_multi: RTL and testbench

- Parametrised successor of the three-FLL APB bridge. Serves NUM_FLL FLL configuration ports from one APB slave using a 4-phase req/ack handshake.
- Adds a per-access timeout with PSLVERR, registered request outputs, a lock status register and sticky lock-loss tracking.
- Sits in the SoC control APB subsystem between the peripheral interconnect and the FLL macros, which run in their own clock domains.

---
 rtl/apb_fll_if_multi.sv | 199 +++++++++++++++++++
 tb/tb_apb_fll_if_multi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fll_if_multi.sv
// apb_fll_if_multi: APB slave bridging to NUM_FLL FLL config ports over a 4-phase req/ack handshake,
// with access timeout, lock status and sticky timeout; `define FLL_LOCK_IRQ_EN adds lock-loss tracking and lock_irq.
module apb_fll_if_multi #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_FLL        = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic [NUM_FLL-1:0]        fll_req,
   output logic [NUM_FLL-1:0]        fll_wrn,
   output logic [2*NUM_FLL-1:0]      fll_add,
   output logic [32*NUM_FLL-1:0]     fll_data,
   input  logic [NUM_FLL-1:0]        fll_ack,
   input  logic [32*NUM_FLL-1:0]     fll_r_data,
   input  logic [NUM_FLL-1:0]        fll_lock,
   output logic                      lock_irq
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, RELEASE} state_e;

   state_e                              state_q, state_d;
   logic [2:0]                          idx_q, idx_d;
   logic                                wrn_q, wrn_d, req_q, req_d, err_q, err_d;
   logic [1:0]                          add_q, add_d;
   logic [31:0]                         wdat_q, wdat_d, rdat_q, rdat_d;
   logic [15:0]                         cnt_q, cnt_d;
   logic [NUM_FLL-1:0]                  to_q, to_d, to_set;
   logic [SYNC_STAGES-1:0][NUM_FLL-1:0] ack_sync_q, ack_sync_d, lock_sync_q, lock_sync_d;
   logic [NUM_FLL-1:0]                  req_o_q, req_o_d, wrn_o_q, wrn_o_d;
   logic [NUM_FLL-1:0][1:0]             add_o_q, add_o_d;
   logic [NUM_FLL-1:0][31:0]            dat_o_q, dat_o_d;
   logic [7:0]                          ack_pad;
   logic [7:0][31:0]                    rdat_pad;
   logic [NUM_FLL-1:0]                  ack_s, lock_s, lost;
   logic                                acc, fll_ok, loc_wr, unused_addr;
   logic [31:0]                         loc_rd;

   assign ack_s       = ack_sync_q[SYNC_STAGES-1];
   assign lock_s      = lock_sync_q[SYNC_STAGES-1];
   assign acc         = PSEL & PENABLE & (state_q == IDLE);
   assign fll_ok      = ({1'b0, PADDR[6:4]} < 4'(NUM_FLL));
   assign loc_wr      = acc & PADDR[7] & PWRITE;
   assign unused_addr = ^{PADDR >> 8, PADDR[1:0]};

   assign fll_req  = req_o_q;
   assign fll_wrn  = wrn_o_q;
   assign fll_add  = add_o_q;
   assign fll_data = dat_o_q;

   // Pad to the full 3-bit index space so idx_q can select without range issues
   always_comb begin
      ack_pad  = 8'(ack_s);
      rdat_pad = '0;
      for (int i = 0; i < NUM_FLL; i++) rdat_pad[i] = fll_r_data[32*i +: 32];
   end

   always_comb begin
      ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], fll_ack};
      lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], fll_lock};
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrn_d   = wrn_q;
      add_d   = add_q;
      wdat_d  = wdat_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      to_set  = '0;
      for (int i = 0; i < NUM_FLL; i++) to_set[i] = (idx_q == 3'(i));
      to_d = (loc_wr && PADDR[3:2] == 2'd2) ? to_q & ~PWDATA[NUM_FLL-1:0] : to_q;
      case (state_q)
         IDLE:
            if (PSEL && PENABLE && !PADDR[7] && fll_ok) begin
               idx_d   = PADDR[6:4];
               wrn_d   = ~PWRITE;
               add_d   = PADDR[3:2];
               wdat_d  = PWDATA;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end
         REQ:
            if (ack_pad[idx_q]) begin
               req_d   = 1'b0;
               rdat_d  = rdat_pad[idx_q];
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               req_d   = 1'b0;
               rdat_d  = '0;
               err_d   = 1'b1;
               to_d    = to_d | to_set;
               state_d = RESP;
            end else begin
               cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
            end
         RESP:    state_d = RELEASE;
         default: state_d = ack_pad[idx_q] ? RELEASE : IDLE;
      endcase
      // Only the addressed port carries live values, and only while a transaction is open
      for (int i = 0; i < NUM_FLL; i++) begin
         req_o_d[i] = req_d && (idx_d == 3'(i));
         wrn_o_d[i] = (state_d != IDLE && idx_d == 3'(i)) ? wrn_d : 1'b1;
         add_o_d[i] = (state_d != IDLE && idx_d == 3'(i)) ? add_d : 2'd0;
         dat_o_d[i] = (state_d != IDLE && idx_d == 3'(i)) ? wdat_d : 32'd0;
      end
   end

   always_comb begin
      loc_rd  = (PADDR[3:2] == 2'd0) ? 32'(lock_s) :
                (PADDR[3:2] == 2'd1) ? 32'(lost) :
                (PADDR[3:2] == 2'd2) ? 32'(to_q) : 32'd0;
      PREADY  = (state_q == RESP) | (acc & (PADDR[7] | ~fll_ok));
      PSLVERR = (state_q == RESP) ? err_q : (acc & ~PADDR[7] & ~fll_ok);
      PRDATA  = (state_q == RESP) ? rdat_q : (acc & PADDR[7] & ~PWRITE) ? loc_rd : 32'd0;
   end

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wrn_q       <= 1'b1;
         add_q       <= '0;
         wdat_q      <= '0;
         req_q       <= 1'b0;
         cnt_q       <= '0;
         rdat_q      <= '0;
         err_q       <= 1'b0;
         to_q        <= '0;
         ack_sync_q  <= '0;
         lock_sync_q <= '0;
         req_o_q     <= '0;
         wrn_o_q     <= '1;
         add_o_q     <= '0;
         dat_o_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wrn_q       <= wrn_d;
         add_q       <= add_d;
         wdat_q      <= wdat_d;
         req_q       <= req_d;
         cnt_q       <= cnt_d;
         rdat_q      <= rdat_d;
         err_q       <= err_d;
         to_q        <= to_d;
         ack_sync_q  <= ack_sync_d;
         lock_sync_q <= lock_sync_d;
         req_o_q     <= req_o_d;
         wrn_o_q     <= wrn_o_d;
         add_o_q     <= add_o_d;
         dat_o_q     <= dat_o_d;
      end

`ifdef FLL_LOCK_IRQ_EN
   logic [NUM_FLL-1:0] lost_q, lost_d, lock_prev_q, lock_prev_d;
   logic               irq_q, irq_d;

   // A hardware set in the same cycle as a W1C clear wins
   always_comb begin
      lost_d      = ((loc_wr && PADDR[3:2] == 2'd1) ? lost_q & ~PWDATA[NUM_FLL-1:0] : lost_q) |
                    (lock_prev_q & ~lock_s);
      lock_prev_d = lock_s;
      irq_d       = |lost_q;
   end

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         lost_q      <= '0;
         lock_prev_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         lost_q      <= lost_d;
         lock_prev_q <= lock_prev_d;
         irq_q       <= irq_d;
      end

   assign lost     = lost_q;
   assign lock_irq = irq_q;
`else
   assign lost     = '0;
   assign lock_irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_fll_if_multi.sv
// tb_apb_fll_if_multi: scoreboard bench for apb_fll_if_multi with a behavioural FLL responder per port.
module tb_apb_fll_if_multi;

   typedef struct {
      logic [31:0] rdata;
      logic        chk;
      logic        err;
      string       name;
   } apb_exp_t;

   typedef struct {
      int          idx;
      logic        wrn;
      logic [1:0]  add;
      logic [31:0] data;
   } fll_exp_t;

   logic         HCLK = 1'b0;
   logic         HRESETn;
   logic [11:0]  PADDR;
   logic [31:0]  PWDATA;
   logic         PWRITE, PSEL, PENABLE;
   logic [31:0]  PRDATA;
   logic         PREADY, PSLVERR;
   logic [3:0]   fll_req, fll_wrn;
   logic [7:0]   fll_add;
   logic [127:0] fll_data;
   logic [3:0]   fll_ack = '0;
   logic [127:0] fll_r_data;
   logic [3:0]   fll_lock;
   logic         lock_irq;

   int errors = 0;
   int checks = 0;
   apb_exp_t apb_q[$];
   fll_exp_t fll_q[$];

   int ack_dly[4];
   int rel_dly[4];
   int req_len[4];
   int cnt[4];
   int rc[4];
   logic [3:0] seen = '0;
   fll_exp_t m_f;
   logic     m_ok;
   int       w;

   apb_fll_if_multi #(
      .APB_ADDR_WIDTH(12),
      .NUM_FLL(4),
      .SYNC_STAGES(2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PWRITE(PWRITE),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .PSLVERR(PSLVERR),
      .fll_req(fll_req),
      .fll_wrn(fll_wrn),
      .fll_add(fll_add),
      .fll_data(fll_data),
      .fll_ack(fll_ack),
      .fll_r_data(fll_r_data),
      .fll_lock(fll_lock),
      .lock_irq(lock_irq)
   );

   always #5 HCLK = ~HCLK;

   // FLL responder: checks each new request against the scoreboard, acks after ack_dly, releases rel_dly after req drops
   always @(negedge HCLK) begin
      for (int i = 0; i < 4; i++) begin
         if (!HRESETn) begin
            fll_ack[i] = 1'b0;
            seen[i]    = 1'b0;
            cnt[i]     = 0;
            rc[i]      = 0;
         end else if (fll_req[i]) begin
            if (!seen[i]) begin
               seen[i] = 1'b1;
               cnt[i]  = 0;
               checks++;
               if (fll_q.size() == 0) begin
                  errors++;
                  $display("FAIL fll_req_unexpected: port %0d requested, no request expected", i);
               end else begin
                  m_f  = fll_q.pop_front();
                  m_ok = (m_f.idx == i) && (fll_wrn[i] === m_f.wrn) &&
                         (fll_add[2*i +: 2] === m_f.add) && (fll_data[32*i +: 32] === m_f.data);
                  for (int j = 0; j < 4; j++)
                     if (j != i)
                        m_ok = m_ok && (fll_wrn[j] === 1'b1) && (fll_add[2*j +: 2] === 2'd0) &&
                               (fll_data[32*j +: 32] === 32'd0);
                  if (!m_ok) begin
                     errors++;
                     $display("FAIL fll_req_snap: port %0d wrn=%b add=%h data=%h (all wrn=%b add=%h), expected port %0d wrn=%b add=%h data=%h others idle",
                              i, fll_wrn[i], fll_add[2*i +: 2], fll_data[32*i +: 32], fll_wrn, fll_add,
                              m_f.idx, m_f.wrn, m_f.add, m_f.data);
                  end
               end
            end
            cnt[i]++;
            if (ack_dly[i] != 0 && cnt[i] >= ack_dly[i]) fll_ack[i] = 1'b1;
         end else if (seen[i]) begin
            req_len[i] = cnt[i];
            seen[i]    = 1'b0;
            rc[i]      = 0;
         end else if (fll_ack[i]) begin
            rc[i]++;
            if (rc[i] >= rel_dly[i]) begin
               fll_ack[i] = 1'b0;
               rc[i]      = 0;
            end
         end
      end
   end

   task automatic apb(input string name, input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic chk, input logic exp_err, output int waits);
      apb_exp_t e;
      fll_exp_t f;
      logic [2:0] idx;
      idx = addr[6:4];
      e.rdata = exp_rd; e.chk = chk && !wr; e.err = exp_err; e.name = name;
      apb_q.push_back(e);
      if (!addr[7] && idx < 3'd4) begin
         f.idx = int'(idx); f.wrn = !wr; f.add = addr[3:2]; f.data = wdata;
         fll_q.push_back(f);
      end
      @(posedge HCLK); #1;
      PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      @(negedge HCLK);
      while (!PREADY && waits < 200) begin
         waits++;
         @(negedge HCLK);
      end
      e = apb_q.pop_front();
      checks++;
      if (!PREADY) begin
         errors++;
         $display("FAIL %s: no PREADY within 200 cycles", e.name);
      end else if (PSLVERR !== e.err || (e.chk && PRDATA !== e.rdata)) begin
         errors++;
         $display("FAIL %s: PSLVERR=%b PRDATA=%h, expected PSLVERR=%b PRDATA=%h (checked=%b)",
                  e.name, PSLVERR, PRDATA, e.err, e.rdata, e.chk);
      end
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset;
      HRESETn = 1'b1;
      #2 HRESETn = 1'b0;
      #3;
      checks += 8;
      if (PREADY !== 1'b0)   begin errors++; $display("FAIL rst_pready: got %b expected 0", PREADY); end
      if (PSLVERR !== 1'b0)  begin errors++; $display("FAIL rst_pslverr: got %b expected 0", PSLVERR); end
      if (PRDATA !== 32'd0)  begin errors++; $display("FAIL rst_prdata: got %h expected 0", PRDATA); end
      if (fll_req !== 4'h0)  begin errors++; $display("FAIL rst_req: got %h expected 0", fll_req); end
      if (fll_wrn !== 4'hf)  begin errors++; $display("FAIL rst_wrn: got %h expected f", fll_wrn); end
      if (fll_add !== 8'h0)  begin errors++; $display("FAIL rst_add: got %h expected 0", fll_add); end
      if (fll_data !== '0)   begin errors++; $display("FAIL rst_data: got %h expected 0", fll_data); end
      if (lock_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", lock_irq); end
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;
   endtask

   task automatic test_write_and_stall;
      ack_dly[1] = 4; rel_dly[1] = 10;
      apb("wr_fll1", 12'h014, 1'b1, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0, w);
      apb("stall_lock_rd", 12'h080, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, w);
      checks++;
      if (w < 5) begin errors++; $display("FAIL back_to_back_stall: waited %0d cycles, required >= 5", w); end
   endtask

   task automatic test_read;
      ack_dly[2] = 1; rel_dly[2] = 1;
      fll_r_data[95:64] = 32'hDEAD_BEEF;
      apb("rd_fll2", 12'h028, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, w);
      checks++;
      if (w != 4) begin errors++; $display("FAIL rd_latency: %0d wait cycles, expected 4", w); end
   endtask

   task automatic test_timeout;
      ack_dly[0] = 0;
      apb("rd_timeout", 12'h000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, w);
      checks++;
      if (req_len[0] != 16) begin errors++; $display("FAIL timeout_req_len: req high %0d cycles, expected 16", req_len[0]); end
      apb("to_status_set", 12'h088, 1'b0, 32'd0, 32'h1, 1'b1, 1'b0, w);
      apb("to_status_w1c", 12'h088, 1'b1, 32'h1, 32'd0, 1'b0, 1'b0, w);
      apb("to_status_clr", 12'h088, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, w);
   endtask

   task automatic test_invalid;
      apb("rd_invalid_idx", 12'h070, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, w);
      checks += 2;
      if (w != 0) begin errors++; $display("FAIL invalid_latency: %0d wait cycles, expected 0", w); end
      if (fll_req !== 4'h0) begin errors++; $display("FAIL invalid_req: got %h expected 0", fll_req); end
   endtask

   task automatic test_lock;
      fll_lock = 4'b1001;
      repeat (4) @(posedge HCLK);
      apb("lock_status", 12'h080, 1'b0, 32'd0, 32'h9, 1'b1, 1'b0, w);
      #1 fll_lock[3] = 1'b0;
      repeat (5) @(posedge HCLK);
`ifdef FLL_LOCK_IRQ_EN
      apb("lock_lost_set", 12'h084, 1'b0, 32'd0, 32'h8, 1'b1, 1'b0, w);
      @(negedge HCLK);
      checks++;
      if (lock_irq !== 1'b1) begin errors++; $display("FAIL lock_irq_set: got %b expected 1", lock_irq); end
      apb("lock_lost_w1c", 12'h084, 1'b1, 32'h8, 32'd0, 1'b0, 1'b0, w);
      apb("lock_lost_clr", 12'h084, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, w);
`else
      apb("lock_lost_off", 12'h084, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, w);
`endif
      @(negedge HCLK);
      checks++;
      if (lock_irq !== 1'b0) begin errors++; $display("FAIL lock_irq_clr: got %b expected 0", lock_irq); end
   endtask

   task automatic test_reset_mid;
      fll_exp_t f;
      ack_dly[0] = 4; rel_dly[0] = 1;
      f.idx = 0; f.wrn = 1'b1; f.add = 2'd1; f.data = 32'd0;
      fll_q.push_back(f);
      @(posedge HCLK); #1;
      PADDR = 12'h004; PWRITE = 1'b0; PWDATA = 32'd0; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      repeat (3) @(posedge HCLK);
      #2 HRESETn = 1'b0;
      #1;
      checks += 2;
      if (fll_req !== 4'h0) begin errors++; $display("FAIL midrst_req: got %h expected 0", fll_req); end
      if (PREADY !== 1'b0)  begin errors++; $display("FAIL midrst_pready: got %b expected 0", PREADY); end
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      apb("wr_after_rst", 12'h004, 1'b1, 32'h1234_5678, 32'd0, 1'b0, 1'b0, w);
   endtask

   initial begin
      PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      fll_r_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      fll_lock = '0;
      for (int i = 0; i < 4; i++) begin ack_dly[i] = 4; rel_dly[i] = 1; req_len[i] = 0; cnt[i] = 0; rc[i] = 0; end
      test_reset;
      test_write_and_stall;
      test_read;
      test_timeout;
      test_invalid;
      test_lock;
      test_reset_mid;
      repeat (5) @(posedge HCLK);
      checks++;
      if (fll_q.size() != 0) begin errors++; $display("FAIL fll_req_missing: %0d expected requests never seen", fll_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
